gate_deadtime: RTL and testbench

Per-phase dead-time insertion and gate protection stage between the SVPWM gate outputs and the inverter gate drivers. It takes the 6-bit gate command, regenerates each phase's complementary high/low pair from the high-side command, and holds both switches off for a programmable number of clocks at every commutation. It also contains a sticky trip latch that forces all gates off on an external fault or, optionally, on an illegal input pair.

---
 rtl/gate_deadtime.sv | 198 +++++++++++++++++++
 tb/tb_gate_deadtime.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_deadtime.sv
// gate_deadtime: per-phase dead-time insertion and gate protection.
//
// Sits between the SVPWM gate command and the inverter gate drivers. Each of
// the three phases rebuilds its complementary high/low pair from the
// high-side command alone and keeps both switches off for dead_time clocks
// at every commutation. A sticky trip latch forces every gate off on an
// external fault (fault_in, double-flop synchronised) and, optionally, on an
// illegal high+low input pair.
//
// Build option:
//   SHOOT_THROUGH_TRIP_EN  - when defined, gate_in[2k] & gate_in[2k+1] for any
//                            phase is a trip with cause bit1. When undefined
//                            the odd (low-side) command bits are ignored and
//                            fault_cause[1] is always 0.

module gate_deadtime #(
    parameter int DT_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DT_W-1:0] dead_time,
    input  logic [5:0]      gate_in,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic [5:0]      gate_out,
    output logic            fault_latched,
    output logic [1:0]      fault_cause
);

    // Per-phase commutation states. Both DT states keep both switches off.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DT_HI = 3'd1,
        HI    = 3'd2,
        DT_LO = 3'd3,
        LO    = 3'd4
    } phase_state_e;

    localparam logic [DT_W-1:0] CNT_ZERO = '0;
    localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);

    logic       fault_meta;
    logic       fault_sync;
    logic       shoot_trip;
    logic       trip;
    logic       clear_ok;
    logic       hold_idle;
    logic       dt_zero;
    logic [2:0] phase_hi;
    logic [2:0] phase_lo;

    // Two-flop synchroniser for the asynchronous external trip input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_meta <= 1'b0;
            fault_sync <= 1'b0;
        end else begin
            fault_meta <= fault_in;
            fault_sync <= fault_meta;
        end
    end

`ifdef SHOOT_THROUGH_TRIP_EN
    // A command asking for both switches of one leg at once is itself a fault.
    assign shoot_trip = (gate_in[0] & gate_in[1])
                      | (gate_in[2] & gate_in[3])
                      | (gate_in[4] & gate_in[5]);
`else
    // Low-side command bits carry no information when the check is disabled.
    logic unused_low_cmds;
    assign unused_low_cmds = ^{gate_in[1], gate_in[3], gate_in[5]};
    assign shoot_trip      = 1'b0;
`endif

    // A trip always wins over a clear request and over the run enable.
    assign trip      = fault_sync | shoot_trip;
    assign clear_ok  = fault_clr & fault_latched & ~trip;
    assign hold_idle = trip | fault_latched | ~en;
    assign dt_zero   = (dead_time == CNT_ZERO);

    // Sticky trip flag and cause bits; new causes accumulate while latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_latched <= 1'b0;
            fault_cause   <= 2'b00;
        end else if (trip) begin
            fault_latched <= 1'b1;
            fault_cause   <= fault_cause | {shoot_trip, fault_sync};
        end else if (clear_ok) begin
            fault_latched <= 1'b0;
            fault_cause   <= 2'b00;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_phase
        phase_state_e    state_q;
        phase_state_e    state_d;
        logic [DT_W-1:0] cnt_q;
        logic [DT_W-1:0] cnt_d;
        logic            cmd;
        logic            cnt_done;
        logic            hi_q;
        logic            lo_q;

        assign cmd      = gate_in[2*k];
        // A count loaded as 0 (only possible on IDLE exit) behaves like 1.
        assign cnt_done = (cnt_q <= CNT_ONE);

        // Next state and dead-time counter for this phase.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (hold_idle) begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = cmd ? DT_HI : DT_LO;
                        cnt_d   = dead_time;
                    end
                    LO: begin
                        if (cmd) begin
                            if (dt_zero) begin
                                state_d = HI;
                                cnt_d   = CNT_ZERO;
                            end else begin
                                state_d = DT_HI;
                                cnt_d   = dead_time;
                            end
                        end
                    end
                    HI: begin
                        if (!cmd) begin
                            if (dt_zero) begin
                                state_d = LO;
                                cnt_d   = CNT_ZERO;
                            end else begin
                                state_d = DT_LO;
                                cnt_d   = dead_time;
                            end
                        end
                    end
                    DT_HI: begin
                        if (!cmd) begin
                            state_d = LO;
                            cnt_d   = CNT_ZERO;
                        end else if (cnt_done) begin
                            state_d = HI;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    DT_LO: begin
                        if (cmd) begin
                            state_d = HI;
                            cnt_d   = CNT_ZERO;
                        end else if (cnt_done) begin
                            state_d = LO;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                endcase
            end
        end

        // State, counter and glitch-free registered gate drives.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= CNT_ZERO;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hi_q    <= (state_d == HI);
                lo_q    <= (state_d == LO);
            end
        end

        assign phase_hi[k] = hi_q;
        assign phase_lo[k] = lo_q;
    end

    assign gate_out = {phase_lo[2], phase_hi[2],
                       phase_lo[1], phase_hi[1],
                       phase_lo[0], phase_hi[0]};

endmodule

// File: tb/tb_gate_deadtime.sv
// tb_gate_deadtime: directed and randomised bench for gate_deadtime with a
// behavioural model of the dead-time and trip rules.

module tb_gate_deadtime;

    localparam int DT_W = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [DT_W-1:0] dead_time;
    logic [5:0]      gate_in;
    logic            fault_in;
    logic            fault_clr;
    logic [5:0]      gate_out;
    logic            fault_latched;
    logic [1:0]      fault_cause;

    int total = 0;
    int bad   = 0;

    // Model: per phase, on_side 0=none 1=high 2=low; in a gap, pend is the
    // side waiting to conduct and left the edges still to wait.
    logic       m_s1;
    logic       m_s2;
    logic       m_latched;
    logic [1:0] m_cause;
    bit         m_idle [3];
    int         m_on   [3];
    int         m_pend [3];
    int         m_left [3];

    logic [2:0]      cmds;
    logic [DT_W-1:0] rdt;
    logic            r_en;
    logic            r_f;
    logic            r_c;
    logic [2:0]      odd;

    gate_deadtime #(.DT_W(DT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .dead_time     (dead_time),
        .gate_in       (gate_in),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .gate_out      (gate_out),
        .fault_latched (fault_latched),
        .fault_cause   (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        m_s1      = 1'b0;
        m_s2      = 1'b0;
        m_latched = 1'b0;
        m_cause   = 2'b00;
        for (int k = 0; k < 3; k++) begin
            m_idle[k] = 1'b1;
            m_on[k]   = 0;
            m_pend[k] = 0;
            m_left[k] = 0;
        end
    endtask

    task automatic modelStep();
        logic ext;
        logic st;
        logic was_latched;
        int   want;
        if (rst) begin
            modelReset();
            return;
        end
        ext = m_s2;
        st  = 1'b0;
`ifdef SHOOT_THROUGH_TRIP_EN
        for (int k = 0; k < 3; k++)
            if (gate_in[2*k] && gate_in[2*k+1]) st = 1'b1;
`endif
        was_latched = m_latched;
        m_s2 = m_s1;
        m_s1 = fault_in;
        if (ext || st) begin
            m_latched = 1'b1;
            m_cause   = m_cause | {st, ext};
            for (int k = 0; k < 3; k++) begin
                m_idle[k] = 1'b1;
                m_on[k]   = 0;
            end
        end else begin
            if (fault_clr && was_latched) begin
                m_latched = 1'b0;
                m_cause   = 2'b00;
            end
            for (int k = 0; k < 3; k++) begin
                want = gate_in[2*k] ? 1 : 2;
                if (was_latched || !en) begin
                    m_idle[k] = 1'b1;
                    m_on[k]   = 0;
                end else if (m_idle[k]) begin
                    m_idle[k] = 1'b0;
                    m_on[k]   = 0;
                    m_pend[k] = want;
                    m_left[k] = (dead_time == 0) ? 1 : int'(dead_time);
                end else if (m_on[k] == 0) begin
                    if (want != m_pend[k]) m_on[k] = want;
                    else if (m_left[k] == 1) m_on[k] = m_pend[k];
                    else m_left[k] = m_left[k] - 1;
                end else if (want != m_on[k]) begin
                    if (dead_time == 0) begin
                        m_on[k] = want;
                    end else begin
                        m_on[k]   = 0;
                        m_pend[k] = want;
                        m_left[k] = int'(dead_time);
                    end
                end
            end
        end
    endtask

    function automatic logic [5:0] expectedGates();
        logic [5:0] g;
        g = 6'b0;
        for (int k = 0; k < 3; k++) begin
            g[2*k]   = (m_on[k] == 1);
            g[2*k+1] = (m_on[k] == 2);
        end
        return g;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("gate_out",      {2'b0, gate_out},      {2'b0, expectedGates()});
        checkOutput("fault_latched", {7'b0, fault_latched}, {7'b0, m_latched});
        checkOutput("fault_cause",   {6'b0, fault_cause},   {6'b0, m_cause});
    endtask

    task automatic applyStimulus(input logic e, input logic [DT_W-1:0] d, input logic [5:0] g,
                                 input logic f, input logic c);
        en        = e;
        dead_time = d;
        gate_in   = g;
        fault_in  = f;
        fault_clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkModel();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 10'd0, 6'h00, 1'b0, 1'b0);
        modelReset();
        $display("[TB] reset");
        tick();
        checkOutput("rst_gate", {2'b0, gate_out}, 8'h00);
        checkOutput("rst_latch", {7'b0, fault_latched}, 8'h00);
        checkOutput("rst_cause", {6'b0, fault_cause}, 8'h00);
        tick();
        rst = 1'b0;

        $display("[TB] idle exit into low side");
        applyStimulus(1'b1, 10'd5, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle_dead", {2'b0, gate_out}, 8'h00);
        end
        tick();
        checkOutput("idle_low_on", {2'b0, gate_out}, 8'h2A);

        $display("[TB] phase a commutation dead time");
        applyStimulus(1'b1, 10'd5, 6'h01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("rise_dead", {2'b0, gate_out}, 8'h28);
        end
        tick();
        checkOutput("rise_hi_on", {2'b0, gate_out}, 8'h29);
        applyStimulus(1'b1, 10'd5, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("fall_dead", {2'b0, gate_out}, 8'h28);
        end
        tick();
        checkOutput("fall_lo_on", {2'b0, gate_out}, 8'h2A);

        $display("[TB] short pulses");
        applyStimulus(1'b1, 10'd5, 6'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("pulse_abort_gap", {2'b0, gate_out}, 8'h28);
        end
        applyStimulus(1'b1, 10'd5, 6'h00, 1'b0, 1'b0);
        tick();
        checkOutput("pulse_abort_lo", {2'b0, gate_out}, 8'h2A);
        applyStimulus(1'b1, 10'd0, 6'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("pulse_dt0_hi", {2'b0, gate_out}, 8'h29);
        end
        applyStimulus(1'b1, 10'd0, 6'h00, 1'b0, 1'b0);
        tick();
        checkOutput("pulse_dt0_lo", {2'b0, gate_out}, 8'h2A);

        $display("[TB] external trip");
        applyStimulus(1'b1, 10'd5, 6'h15, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("all_hi", {2'b0, gate_out}, 8'h15);
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("mixed_on", {2'b0, gate_out}, 8'h25);
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b0);
        tick();
        checkOutput("trip_sync_delay", {2'b0, gate_out}, 8'h25);
        tick();
        checkOutput("trip_gate", {2'b0, gate_out}, 8'h00);
        checkOutput("trip_latch", {7'b0, fault_latched}, 8'h01);
        checkOutput("trip_cause", {6'b0, fault_cause}, 8'h01);
        applyStimulus(1'b0, 10'd5, 6'h05, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("trip_hold_latch", {7'b0, fault_latched}, 8'h01);
        checkOutput("trip_hold_gate", {2'b0, gate_out}, 8'h00);
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b1);
        tick();
        checkOutput("clr_latch", {7'b0, fault_latched}, 8'h00);
        checkOutput("clr_cause", {6'b0, fault_cause}, 8'h00);
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("clr_dead", {2'b0, gate_out}, 8'h00);
        end
        tick();
        checkOutput("clr_conduct", {2'b0, gate_out}, 8'h25);

        $display("[TB] clear collides with trip");
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b1, 1'b1);
        tick();
        checkOutput("clr_vs_trip", {7'b0, fault_latched}, 8'h01);
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(1'b1, 10'd5, 6'h05, 1'b0, 1'b1);
        tick();
        checkOutput("clr_after", {7'b0, fault_latched}, 8'h00);

        $display("[TB] both commands of phase a");
        applyStimulus(1'b1, 10'd5, 6'h03, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick();
`ifdef SHOOT_THROUGH_TRIP_EN
        checkOutput("st_latch", {7'b0, fault_latched}, 8'h01);
        checkOutput("st_cause", {6'b0, fault_cause}, 8'h02);
        checkOutput("st_gate", {2'b0, gate_out}, 8'h00);
`else
        checkOutput("st_latch", {7'b0, fault_latched}, 8'h00);
        checkOutput("st_gate", {2'b0, gate_out}, 8'h29);
`endif
        applyStimulus(1'b1, 10'd5, 6'h00, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 10'd5, 6'h00, 1'b0, 1'b0);
        tick();

        $display("[TB] reset mid count");
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_gate", {2'b0, gate_out}, 8'h00);
        checkOutput("rst_mid_latch", {7'b0, fault_latched}, 8'h00);
        modelReset();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] random");
        cmds = 3'b000;
        rdt  = 10'd3;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 9) == 0) cmds[k] = ~cmds[k];
            if ($urandom_range(0, 39) == 0) rdt = DT_W'($urandom_range(0, 6));
            for (int k = 0; k < 3; k++) odd[k] = ($urandom_range(0, 59) == 0);
            r_en = ($urandom_range(0, 49) != 0);
            r_f  = ($urandom_range(0, 119) == 0);
            r_c  = ($urandom_range(0, 14) == 0);
            applyStimulus(r_en, rdt, {odd[2], cmds[2], odd[1], cmds[1], odd[0], cmds[0]}, r_f, r_c);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
